// File: rtl/fft_r22sdf_frame_ctrl_if.sv
// rtl/fft_r22sdf_frame_ctrl_if.sv - sample-in / bin-out streams around the FFT frame controller
interface fft_r22sdf_frame_ctrl_if #(
    parameter int INPUT_WIDTH  = 14,
    parameter int OUTPUT_WIDTH = 25,
    parameter int BIN_WIDTH    = 10
);
    logic                    s_valid_i;
    logic [INPUT_WIDTH-1:0]  s_re_i;
    logic [INPUT_WIDTH-1:0]  s_im_i;
    logic                    m_valid_o;
    logic                    m_first_o;
    logic                    m_last_o;
    logic [BIN_WIDTH-1:0]    m_bin_o;
    logic [OUTPUT_WIDTH-1:0] m_re_o;
    logic [OUTPUT_WIDTH-1:0] m_im_o;

    // slave: the controller; master: the sample source / bin sink
    modport slave (
        input  s_valid_i, s_re_i, s_im_i,
        output m_valid_o, m_first_o, m_last_o, m_bin_o, m_re_o, m_im_o
    );
    modport master (
        output s_valid_i, s_re_i, s_im_i,
        input  m_valid_o, m_first_o, m_last_o, m_bin_o, m_re_o, m_im_o
    );
endinterface

// File: rtl/fft_r22sdf_frame_ctrl.sv
// rtl/fft_r22sdf_frame_ctrl.sv - arms, feeds, drains and tags frames of a stall-free R2^2 SDF FFT core
module fft_r22sdf_frame_ctrl #(
    parameter int N               = 1024,
    parameter int INPUT_WIDTH     = 14,
    parameter int OUTPUT_WIDTH    = 25,
    parameter int FRAME_CNT_WIDTH = 16,
    parameter int RST_CYCLES      = 4,
    parameter int DRAIN_MAX       = 2 * N
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic [FRAME_CNT_WIDTH-1:0] frames_i,
    fft_r22sdf_frame_ctrl_if.slave     st,
    output logic                       fft_rst_n_o,
    output logic [INPUT_WIDTH-1:0]     fft_re_o,
    output logic [INPUT_WIDTH-1:0]     fft_im_o,
    input  logic                       fft_sync_i,
    input  logic [$clog2(N)-1:0]       fft_ctr_i,
    input  logic [OUTPUT_WIDTH-1:0]    fft_re_i,
    input  logic [OUTPUT_WIDTH-1:0]    fft_im_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       gap_err_o,
    output logic                       timeout_err_o
);
    localparam int BW  = $clog2(N);
    localparam int FCW = FRAME_CNT_WIDTH;
    localparam int AW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int WW  = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_ABORT = 3'd5;

    logic [2:0]     state;
    logic [AW-1:0]  arm_cnt;
    logic [BW-1:0]  smp_cnt;
    logic [FCW-1:0] frames_q;
    logic [FCW-1:0] in_frames;
    logic [FCW-1:0] out_frames;
    logic [WW-1:0]  wd_cnt;
    logic           stop_seen;

    logic           finite;
    logic           final_frame;
    logic           smp_last;
    logic           gap;
    logic           wd_expired;
    logic           pending;
    logic           out_ok;
    logic [FCW-1:0] in_eff;

    // Outstanding frames are judged by a modular difference so the counters may wrap freely.
    always_comb begin
        finite      = (frames_q != '0);
        smp_last    = (smp_cnt == {BW{1'b1}});
        final_frame = finite ? ((in_frames + FCW'(1)) == frames_q) : (stop_seen | stop_i);
        in_eff      = (state == S_RUN) ? (in_frames + FCW'(1)) : in_frames;
        pending     = (in_eff != out_frames);
        gap         = (state == S_RUN) & ~st.s_valid_i;
        wd_expired  = (state == S_DRAIN) & pending & (wd_cnt == WW'(DRAIN_MAX - 1));
        out_ok      = fft_sync_i & ((state == S_RUN) | (state == S_DRAIN)) & pending
                    & ~gap & ~wd_expired;
    end

    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            arm_cnt       <= '0;
            smp_cnt       <= '0;
            frames_q      <= '0;
            in_frames     <= '0;
            out_frames    <= '0;
            wd_cnt        <= '0;
            stop_seen     <= 1'b0;
            fft_rst_n_o   <= 1'b0;
            fft_re_o      <= '0;
            fft_im_o      <= '0;
            done_o        <= 1'b0;
            gap_err_o     <= 1'b0;
            timeout_err_o <= 1'b0;
            st.m_valid_o  <= 1'b0;
            st.m_first_o  <= 1'b0;
            st.m_last_o   <= 1'b0;
            st.m_bin_o    <= '0;
            st.m_re_o     <= '0;
            st.m_im_o     <= '0;
        end else begin
            done_o       <= 1'b0;
            fft_re_o     <= '0;
            fft_im_o     <= '0;
            st.m_valid_o <= out_ok;
            st.m_first_o <= out_ok & (fft_ctr_i == '0);
            st.m_last_o  <= out_ok & (fft_ctr_i == {BW{1'b1}});
            st.m_bin_o   <= fft_ctr_i;
            st.m_re_o    <= fft_re_i;
            st.m_im_o    <= fft_im_i;
            if (out_ok && (fft_ctr_i == {BW{1'b1}}))
                out_frames <= out_frames + FCW'(1);
            if (!finite && stop_i && ((state == S_WAIT) || (state == S_RUN)))
                stop_seen <= 1'b1;

            case (state)
                S_IDLE: begin
                    fft_rst_n_o <= 1'b0;
                    if (start_i) begin
                        frames_q      <= frames_i;
                        gap_err_o     <= 1'b0;
                        timeout_err_o <= 1'b0;
                        in_frames     <= '0;
                        out_frames    <= '0;
                        smp_cnt       <= '0;
                        arm_cnt       <= '0;
                        wd_cnt        <= '0;
                        stop_seen     <= 1'b0;
                        state         <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (arm_cnt == AW'(RST_CYCLES - 1)) begin
                        fft_rst_n_o <= 1'b1;
                        state       <= S_WAIT;
                    end else begin
                        arm_cnt <= arm_cnt + AW'(1);
                    end
                end
                S_WAIT: begin
                    if (st.s_valid_i) begin
                        fft_re_o <= st.s_re_i;
                        fft_im_o <= st.s_im_i;
                        smp_cnt  <= BW'(1);
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    // The core has no valid input: any hole would corrupt every frame in flight.
                    if (gap) begin
                        gap_err_o   <= 1'b1;
                        fft_rst_n_o <= 1'b0;
                        state       <= S_ABORT;
                    end else begin
                        fft_re_o <= st.s_re_i;
                        fft_im_o <= st.s_im_i;
                        smp_cnt  <= smp_cnt + BW'(1);
                        if (smp_last) begin
                            in_frames <= in_frames + FCW'(1);
                            if (final_frame) begin
                                wd_cnt <= '0;
                                state  <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!pending) begin
                        done_o      <= 1'b1;
                        fft_rst_n_o <= 1'b0;
                        state       <= S_IDLE;
                    end else if (wd_expired) begin
                        timeout_err_o <= 1'b1;
                        fft_rst_n_o   <= 1'b0;
                        state         <= S_ABORT;
                    end else begin
                        wd_cnt <= wd_cnt + WW'(1);
                    end
                end
                S_ABORT: begin
                    fft_rst_n_o <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_r22sdf_frame_ctrl.sv
// tb/tb_fft_r22sdf_frame_ctrl.sv - scoreboard bench for the FFT frame controller with an impulse-only core stub
module tb_fft_r22sdf_frame_ctrl;
    localparam int N      = 16;
    localparam int IW     = 14;
    localparam int OW     = 25;
    localparam int FCW    = 16;
    localparam int BW     = 4;
    localparam int CORE_D = 3;

    logic           clk;
    logic           rst;
    logic           start_i;
    logic           stop_i;
    logic [FCW-1:0] frames_i;
    logic           fft_rst_n;
    logic [IW-1:0]  fft_re_o, fft_im_o;
    logic           fft_sync;
    logic [BW-1:0]  fft_ctr;
    logic [OW-1:0]  fft_re_i, fft_im_i;
    logic           busy_o, done_o, gap_err_o, timeout_err_o;

    fft_r22sdf_frame_ctrl_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .BIN_WIDTH(BW)) sif ();

    fft_r22sdf_frame_ctrl #(
        .N(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .FRAME_CNT_WIDTH(FCW),
        .RST_CYCLES(4), .DRAIN_MAX(2 * N)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .stop_i(stop_i), .frames_i(frames_i),
        .st(sif), .fft_rst_n_o(fft_rst_n), .fft_re_o(fft_re_o), .fft_im_o(fft_im_o),
        .fft_sync_i(fft_sync), .fft_ctr_i(fft_ctr), .fft_re_i(fft_re_i), .fft_im_i(fft_im_i),
        .busy_o(busy_o), .done_o(done_o), .gap_err_o(gap_err_o), .timeout_err_o(timeout_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0, n_first = 0, n_last = 0, n_done = 0;
    int frame_id = 0;
    int v0, d0, f0, l0;
    logic [63:0] want_q[$];
    logic [63:0] mon_e;
    bit sync_kill = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, want);
        end
    endtask

    function automatic logic [BW-1:0] bitrev(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        for (int b = 0; b < BW; b++) r[b] = v[BW-1-b];
        return r;
    endfunction

    function automatic logic [OW-1:0] sext(input logic [IW-1:0] v);
        return {{(OW-IW){v[IW-1]}}, v};
    endfunction

    function automatic logic [63:0] pack(input logic f, input logic l, input logic [BW-1:0] b,
                                         input logic [OW-1:0] re, input logic [OW-1:0] im);
        return 64'({f, l, b, re, im});
    endfunction

    // Core stub: DFT of an impulse at sample 0 is flat, so every bin carries that sample.
    int          core_cnt;
    logic        core_started;
    logic [IW-1:0] s0_re[64];
    logic [IW-1:0] s0_im[64];
    int          cp, cpp, cfi;

    always @(posedge clk) begin
        if (!fft_rst_n) begin
            core_started <= 1'b0;
            core_cnt     <= 0;
        end else if (!core_started) begin
            core_started <= 1'b1;
        end else begin
            if (core_cnt % N == 0) begin
                s0_re[(core_cnt / N) % 64] <= fft_re_o;
                s0_im[(core_cnt / N) % 64] <= fft_im_o;
            end
            core_cnt <= core_cnt + 1;
        end
    end

    always_comb begin
        cp       = core_cnt - N - CORE_D;
        cpp      = (cp < 0) ? 0 : cp;
        cfi      = (cpp / N) % 64;
        fft_sync = !sync_kill && core_started && (cp >= 0);
        fft_ctr  = fft_sync ? bitrev(BW'(cpp % N)) : '0;
        fft_re_i = fft_sync ? sext(s0_re[cfi]) : '0;
        fft_im_i = fft_sync ? sext(s0_im[cfi]) : '0;
    end

    always @(negedge clk) begin
        if (done_o) n_done++;
        if (sif.m_valid_o) begin
            n_valid++;
            if (sif.m_first_o) n_first++;
            if (sif.m_last_o) n_last++;
            check("q_nonempty", 64'(want_q.size() > 0), 1);
            if (want_q.size() > 0) begin
                mon_e = want_q.pop_front();
                check("bin", pack(sif.m_first_o, sif.m_last_o, sif.m_bin_o, sif.m_re_o, sif.m_im_o), mon_e);
            end
        end else begin
            check("qual_idle", {sif.m_first_o, sif.m_last_o}, 0);
        end
    end

    task automatic snap();
        v0 = n_valid; d0 = n_done; f0 = n_first; l0 = n_last;
    endtask

    task automatic start_run(input int nfr);
        int low;
        start_i  = 1'b1;
        frames_i = FCW'(nfr);
        @(negedge clk);
        start_i  = 1'b0;
        frames_i = FCW'(5);
        check("err_clr", {gap_err_o, timeout_err_o}, 0);
        check("busy_arm", busy_o, 1);
        low = 0;
        while (!fft_rst_n && low < 20) begin
            low++;
            @(negedge clk);
        end
        check("arm_len", low, 4);
    endtask

    task automatic drive(input int nsmp, input bit push, input int gap_at, input int stop_at, input int start_at);
        logic [IW-1:0] a_re, a_im;
        logic [BW-1:0] b;
        for (int i = 0; i < nsmp; i++) begin
            if (i == gap_at) begin
                sif.s_valid_i = 1'b0;
                sif.s_re_i    = '0;
                sif.s_im_i    = '0;
                @(negedge clk);
                check("gap_err", gap_err_o, 1);
                check("gap_rst_n", fft_rst_n, 0);
                check("gap_mvalid", sif.m_valid_o, 0);
                @(negedge clk);
                check("gap_idle", busy_o, 0);
                break;
            end
            sif.s_valid_i = 1'b1;
            if (i % N == 0) begin
                a_re = IW'(100 + 13 * frame_id);
                a_im = IW'(7 + 3 * frame_id);
                frame_id++;
                sif.s_re_i = a_re;
                sif.s_im_i = a_im;
                if (push) begin
                    for (int j = 0; j < N; j++) begin
                        b = bitrev(BW'(j));
                        want_q.push_back(pack(b == '0, b == '1, b, sext(a_re), sext(a_im)));
                    end
                end
            end else begin
                sif.s_re_i = '0;
                sif.s_im_i = '0;
            end
            stop_i  = (i == stop_at);
            start_i = (i == start_at);
            if (i == start_at) frames_i = FCW'(7);
            @(negedge clk);
        end
        sif.s_valid_i = 1'b0;
        sif.s_re_i    = '0;
        sif.s_im_i    = '0;
        stop_i        = 1'b0;
        start_i       = 1'b0;
    endtask

    task automatic finish_run(input int nfr);
        int cnt;
        cnt = 0;
        while (!done_o && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check("done_seen", done_o, 1);
        check("busy_at_done", busy_o, 0);
        repeat (40) @(negedge clk);
        check("q_empty", want_q.size(), 0);
        check("valid_cnt", n_valid - v0, nfr * N);
        check("first_cnt", n_first - f0, nfr);
        check("last_cnt", n_last - l0, nfr);
        check("done_cnt", n_done - d0, 1);
        check("no_err", {gap_err_o, timeout_err_o}, 0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; frames_i = '0;
        sif.s_valid_i = 1'b0; sif.s_re_i = '0; sif.s_im_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {fft_rst_n, fft_re_o, fft_im_o, sif.m_valid_o, sif.m_first_o, sif.m_last_o,
                           sif.m_bin_o, busy_o, done_o, gap_err_o, timeout_err_o}, 0);
        check("rst_data", {sif.m_re_o, sif.m_im_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        // two finite frames
        snap(); start_run(2); drive(2 * N, 1, -1, -1, -1); finish_run(2);

        // gap at sample 7
        snap(); start_run(1); drive(N, 0, 7, -1, -1);
        repeat (5) @(negedge clk);
        check("gap_sticky", gap_err_o, 1);
        check("gap_no_valid", n_valid - v0, 0);
        check("gap_no_done", n_done - d0, 0);

        // continuous, stop during the second frame
        snap(); start_run(0); drive(2 * N, 1, -1, 20, -1); finish_run(2);

        // core never syncs: drain watchdog
        snap(); sync_kill = 1'b1; start_run(1); drive(N, 0, -1, -1, -1);
        cnt = 0;
        while (!timeout_err_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("wd_cycles", cnt, 2 * N);
        check("to_rst_n", fft_rst_n, 0);
        @(negedge clk);
        check("to_idle", busy_o, 0);
        repeat (5) @(negedge clk);
        check("to_no_done", n_done - d0, 0);
        check("to_no_valid", n_valid - v0, 0);
        check("to_sticky", timeout_err_o, 1);
        sync_kill = 1'b0;

        // asynchronous reset mid-run, then a clean run
        start_run(2); drive(10, 0, -1, -1, -1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctrl", {fft_rst_n, fft_re_o, fft_im_o, sif.m_valid_o, sif.m_first_o, sif.m_last_o,
                               sif.m_bin_o, busy_o, done_o, gap_err_o, timeout_err_o}, 0);
        check("mid_rst_data", {sif.m_re_o, sif.m_im_o}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        snap(); start_run(2); drive(2 * N, 1, -1, -1, -1); finish_run(2);

        // start and stop during a finite run are ignored
        snap(); start_run(2); drive(2 * N, 1, -1, 20, 5); finish_run(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
